multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-subset datapath with bounded memory waits.
// Illegal instructions and memory timeouts park the machine in HALT until reset.
module multicycle_control #(
    parameter int WAIT_MAX = 15
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Fn,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        HALT   = 4'd10
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic             fnLegal;
    logic [3:0]       fnAluOp;
    logic             timeout;

    always_comb begin
        fnLegal = 1'b1;
        fnAluOp = ALU_ADD;
        case (Fn)
            6'd32:   fnAluOp = ALU_ADD;
            6'd34:   fnAluOp = ALU_SUB;
            6'd36:   fnAluOp = ALU_AND;
            6'd37:   fnAluOp = ALU_OR;
            6'd0:    fnAluOp = ALU_SLL;
            6'd2:    fnAluOp = ALU_SRL;
            6'd3:    fnAluOp = ALU_SRA;
            6'd42:   fnAluOp = ALU_SLT;
            default: fnLegal = 1'b0;
        endcase
    end

    // The current cycle is the WAIT_MAX-th consecutive stalled one.
    assign timeout = !MemReady && (waitCnt_q == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= FETCH;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = '0;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        MemtoReg  = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = ALU_AND;
        PCSource  = 2'b00;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                // Write strobes are gated so nothing commits while reset is held.
                if (MemReady) begin
                    IRWrite = Rst_n;
                    PCWrite = Rst_n;
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = HALT;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                case (Opcode)
                    6'd0:         state_d = fnLegal ? EXEC : HALT;
                    6'd2:         state_d = JUMP;
                    6'd4, 6'd5:   state_d = BRANCH;
                    6'd35, 6'd43: state_d = MEMADR;
                    default:      state_d = HALT;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
                state_d = (Opcode == 6'd35) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady)     state_d = MEMWB;
                else if (timeout) state_d = HALT;
                else              waitCnt_d = waitCnt_q + CNT_W'(1);
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    InstrDone = 1'b1;
                    state_d   = FETCH;
                end else if (timeout) begin
                    state_d = HALT;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = fnAluOp;
                state_d = RWB;
            end
            RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
                ALUOp     = fnAluOp;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALU_SUB;
                PCSource  = 2'b01;
                PCWrite   = (Opcode == 6'd4) ? Zero : !Zero;
                InstrDone = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                PCSource  = 2'b10;
                PCWrite   = 1'b1;
                InstrDone = 1'b1;
                state_d   = FETCH;
            end
            HALT: begin
                Illegal = 1'b1;
            end
            default: begin
                Illegal = 1'b1;
                state_d = HALT;
            end
        endcase
    end

    assign State = state_q;

endmodule
